// File: rtl/in_pcm_rx_if.sv
// in_pcm_rx_if: serial PCM input, signal estimate and D valid/ready output bundle
interface in_pcm_rx_if;
   logic        law;
   logic        bclk_en;
   logic        fs;
   logic        sdata;
   logic [14:0] se;
   logic        d_ready;
   logic [7:0]  s;
   logic [13:0] sl;
   logic [15:0] d;
   logic        d_valid;
   logic        overrun;
   logic        frame_err;
   modport master (
      output law, bclk_en, fs, sdata, se, d_ready,
      input  s, sl, d, d_valid, overrun, frame_err
   );
   modport slave (
      input  law, bclk_en, fs, sdata, se, d_ready,
      output s, sl, d, d_valid, overrun, frame_err
   );
endinterface

// File: rtl/in_pcm_rx.sv
// in_pcm_rx: deserializes G.711 codewords, expands them to 14-bit linear PCM and
// presents D = SL - SE through a one-entry valid/ready output register.
module in_pcm_rx #(
   parameter int BITS = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   in_pcm_rx_if.slave io
);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t          r_state, w_next;
   logic            w_start, w_shift, w_done, w_ferr;
   logic [BITS-1:0] r_sh, w_byte;
   logic [2:0]      r_cnt;
   logic            r_s1_v, r_s1_law;
   logic [7:0]      r_s1_s;
   logic [14:0]     r_s1_se;
   logic            r_s2_v;
   logic [7:0]      r_s2_s;
   logic [13:0]     r_s2_sl;
   logic [14:0]     r_s2_se;
   logic            r_s3_v;
   logic [7:0]      r_s3_s;
   logic [13:0]     r_s3_sl;
   logic [15:0]     r_s3_d;
   logic [7:0]      r_s;
   logic [13:0]     r_sl;
   logic [15:0]     r_d;
   logic            r_dv, r_ovr, r_ferr;
   logic [7:0]      w_x;
   logic            w_neg;
   logic [2:0]      w_e;
   logic [3:0]      w_m;
   logic [5:0]      w_base;
   logic [13:0]     w_ua, w_aa, w_mag, w_sl;
   logic [15:0]     w_d;
   logic            w_ld;
   assign w_byte = {r_sh[BITS-2:0], io.sdata};
   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_shift = 1'b0;
      w_done  = 1'b0;
      w_ferr  = 1'b0;
      case (r_state)
         IDLE: if (io.bclk_en && io.fs) begin
            w_start = 1'b1;
            w_next  = SHIFT;
         end
         SHIFT: if (io.bclk_en) begin
            if (io.fs) begin
               w_ferr  = 1'b1;
               w_start = 1'b1;
            end else if (r_cnt == 3'(BITS - 1)) begin
               w_done = 1'b1;
               w_next = IDLE;
            end else begin
               w_shift = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end
   // EXPAND: 2m+33 is {1, m, 1}; A-law segment 0 has no implicit leading one
   always_comb begin
      w_x    = r_s1_s ^ (r_s1_law ? 8'h55 : 8'hFF);
      w_neg  = r_s1_law ? ~w_x[7] : w_x[7];
      w_e    = w_x[6:4];
      w_m    = w_x[3:0];
      w_base = {1'b1, w_m, 1'b1};
      w_ua   = (14'(w_base) << w_e) - 14'd33;
      w_aa   = ((w_e == 3'd0) ? 14'({w_m, 1'b1}) : 14'(w_base) << (w_e - 3'd1)) << 1;
      w_mag  = r_s1_law ? w_aa : w_ua;
      w_sl   = w_neg ? -w_mag : w_mag;
   end
   assign w_d  = {{2{r_s2_sl[13]}}, r_s2_sl} - {r_s2_se[14], r_s2_se};
   assign w_ld = r_s3_v && (!r_dv || io.d_ready);
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_sh    <= (w_start || w_shift) ? (w_start ? BITS'(io.sdata) : w_byte) : r_sh;
         r_cnt   <= w_start ? 3'd1 : w_shift ? r_cnt + 3'd1 : w_done ? 3'd0 : r_cnt;
      end
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1_v   <= 1'b0;
         r_s1_law <= 1'b0;
         r_s1_s   <= '0;
         r_s1_se  <= '0;
         r_s2_v   <= 1'b0;
         r_s2_s   <= '0;
         r_s2_sl  <= '0;
         r_s2_se  <= '0;
         r_s3_v   <= 1'b0;
         r_s3_s   <= '0;
         r_s3_sl  <= '0;
         r_s3_d   <= '0;
      end else begin
         r_s1_v   <= w_done;
         r_s1_law <= w_done ? io.law : r_s1_law;
         r_s1_s   <= w_done ? w_byte : r_s1_s;
         r_s1_se  <= w_done ? io.se : r_s1_se;
         r_s2_v   <= r_s1_v;
         r_s2_s   <= r_s1_v ? r_s1_s : r_s2_s;
         r_s2_sl  <= r_s1_v ? w_sl : r_s2_sl;
         r_s2_se  <= r_s1_v ? r_s1_se : r_s2_se;
         r_s3_v   <= r_s2_v;
         r_s3_s   <= r_s2_v ? r_s2_s : r_s3_s;
         r_s3_sl  <= r_s2_v ? r_s2_sl : r_s3_sl;
         r_s3_d   <= r_s2_v ? w_d : r_s3_d;
      end
   end
   // output register holds until consumed; a result arriving while full is dropped
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s    <= '0;
         r_sl   <= '0;
         r_d    <= '0;
         r_dv   <= 1'b0;
         r_ovr  <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         r_s    <= w_ld ? r_s3_s : r_s;
         r_sl   <= w_ld ? r_s3_sl : r_sl;
         r_d    <= w_ld ? r_s3_d : r_d;
         r_dv   <= w_ld || (r_dv && !io.d_ready);
         r_ovr  <= r_s3_v && !w_ld;
         r_ferr <= w_ferr;
      end
   end
   assign io.s         = r_s;
   assign io.sl        = r_sl;
   assign io.d         = r_d;
   assign io.d_valid   = r_dv;
   assign io.overrun   = r_ovr;
   assign io.frame_err = r_ferr;
endmodule

// File: tb/tb_in_pcm_rx.sv
// tb_in_pcm_rx: randomized serial stimulus, scoreboard of expected results
// against a G.711 EXPAND reference model and directed boundary cases.
module tb_in_pcm_rx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   in_pcm_rx_if bus();
   in_pcm_rx #(.BITS(8)) dut (.i_clk(clk), .i_rst(rst), .io(bus));
   typedef struct packed {
      logic [7:0]  s;
      logic [13:0] sl;
      logic [15:0] d;
   } exp_t;
   exp_t q[$];
   int n_chk = 0;
   int n_err = 0;
   int n_ovr = 0;
   int n_ferr = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic int ref_sl(input bit law, input int s);
      int x, e, m, mag;
      bit neg;
      x = law ? (s ^ 85) : (s ^ 255);
      e = (x / 16) % 8;
      m = x % 16;
      if (!law) begin
         neg = (x >= 128);
         mag = (2 * m + 33) * (2 ** e) - 33;
      end else begin
         neg = (x < 128);
         mag = (e == 0) ? (2 * m + 1) : (2 * m + 33) * (2 ** (e - 1));
         mag = mag * 2;
      end
      return neg ? -mag : mag;
   endfunction
   function automatic exp_t mk_exp(input bit law, input logic [7:0] s, input logic [14:0] se);
      int sl, sei;
      exp_t r;
      sl = ref_sl(law, int'(s));
      sei = se[14] ? int'(se) - 32768 : int'(se);
      r.s = s;
      r.sl = 14'(sl);
      r.d = 16'(sl - sei);
      return r;
   endfunction
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.overrun) n_ovr++;
         if (bus.frame_err) n_ferr++;
         if (bus.d_valid) begin
            if (q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_valid: got d_valid=1 expected no pending result");
            end else begin
               check("out_S", bus.s, q[0].s);
               check("out_SL", bus.sl, q[0].sl);
               check("out_D", bus.d, q[0].d);
               if (bus.d_ready) void'(q.pop_front());
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive_bit(input bit f, input bit b, input int gap);
      repeat (gap) begin
         bus.bclk_en = 1'b0;
         bus.fs = 1'($urandom);
         bus.sdata = 1'($urandom);
         tick();
      end
      bus.bclk_en = 1'b1;
      bus.fs = f;
      bus.sdata = b;
      tick();
      bus.bclk_en = 1'b0;
      bus.fs = 1'b0;
   endtask
   task automatic send(input bit law, input logic [7:0] s, input logic [14:0] se, input int gapmax, input bit push);
      bus.law = law;
      bus.se = se;
      for (int i = 7; i >= 0; i--) drive_bit(i == 7, s[i], gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
      if (push) q.push_back(mk_exp(law, s, se));
   endtask
   task automatic drain();
      for (int i = 0; i < 100 && q.size() != 0; i++) tick();
      check("drain", q.size(), 0);
   endtask
   task automatic const_test(input bit law, input logic [7:0] s, input logic [14:0] se,
                             input logic [13:0] esl, input logic [15:0] ed);
      send(law, s, se, 0, 1);
      tick();
      tick();
      check("lat_early_dv", bus.d_valid, 0);
      tick();
      check("lat_dv", bus.d_valid, 1);
      check("const_SL", bus.sl, esl);
      check("const_D", bus.d, ed);
      repeat (4) tick();
   endtask
   initial begin
      int o0, f0;
      bus.law = 1'b0;
      bus.bclk_en = 1'b0;
      bus.fs = 1'b0;
      bus.sdata = 1'b0;
      bus.se = '0;
      bus.d_ready = 1'b1;
      repeat (3) tick();
      check("rst_S", bus.s, 0);
      check("rst_SL", bus.sl, 0);
      check("rst_D", bus.d, 0);
      check("rst_dv", bus.d_valid, 0);
      check("rst_ovr", bus.overrun, 0);
      check("rst_ferr", bus.frame_err, 0);
      rst = 1'b0;
      repeat (2) tick();
      const_test(1'b0, 8'hFF, 15'h0000, 14'h0000, 16'h0000);
      const_test(1'b0, 8'h00, 15'h0000, 14'h20A1, 16'hE0A1);
      const_test(1'b0, 8'h80, 15'h0000, 14'h1F5F, 16'h1F5F);
      const_test(1'b1, 8'hD5, 15'h0003, 14'h0002, 16'hFFFF);
      const_test(1'b1, 8'h2A, 15'h0000, 14'h2080, 16'hE080);
      drain();
      o0 = n_ovr;
      bus.d_ready = 1'b0;
      send(1'b0, 8'h5A, 15'h1234, 1, 1);
      send(1'b1, 8'hC3, 15'h7ABC, 1, 0);
      repeat (5) tick();
      check("ovr_count", n_ovr - o0, 1);
      check("ovr_dv_held", bus.d_valid, 1);
      bus.d_ready = 1'b1;
      tick();
      bus.d_ready = 1'b0;
      tick();
      check("accept_dv_clear", bus.d_valid, 0);
      check("ovr_queue", q.size(), 0);
      bus.d_ready = 1'b1;
      f0 = n_ferr;
      for (int i = 0; i < 4; i++) drive_bit(i == 0, 1'($urandom), 1);
      send(1'b1, 8'h9E, 15'($urandom), 1, 1);
      drain();
      check("ferr_count", n_ferr - f0, 1);
      for (int i = 0; i < 4; i++) drive_bit(i == 0, 1'($urandom), 0);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rst_abort_dv", bus.d_valid, 0);
      end
      o0 = n_ovr;
      f0 = n_ferr;
      for (int l = 0; l < 2; l++)
         for (int s = 0; s < 256; s++) send(1'(l), 8'(s), 15'($urandom), 0, 1);
      drain();
      check("stream_ovr", n_ovr - o0, 0);
      for (int i = 0; i < 64; i++) send(1'($urandom), 8'($urandom), 15'($urandom), 3, 1);
      drain();
      check("random_ovr", n_ovr - o0, 0);
      check("random_ferr", n_ferr - f0, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end within time limit");
      $fatal(1);
   end
endmodule
